ex_mem_reg: RTL and testbench
=============================

Name: ex_mem_reg

Overview:
- EX/MEM pipeline register of the 5-stage MIPS core.
- Captures the execute-stage ALU result, the store operand (post-forwarding B value) and control bits, and pre-computes memory byte-enables, store-data lane replication and alignment errors.
- Drives the EX stage's memory-forwarding path.
- Supports hold from the memory stage, flush from hazard/exception logic, and a committed-instruction counter.

Parameters:
- DATA_W, 32, datapath width.
- REG_W, 5, register-index width.
- CNT_W, 32, width of the instruction counter.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- hold_i  in  1  memory stage busy; freeze the register.
- flush_i  in  1  kill the instruction entering from EX (insert bubble).
- ex_valid_i  in  1  EX holds a real instruction.
- alu_result_i  in  DATA_W  ALU output (address or result).
- store_data_i  in  DATA_W  forwarded B operand.
- rd_i  in  REG_W  destination register.
- opcode_i  in  6  instruction opcode.
- regwrite_i, memread_i, memwrite_i, memtoreg_i  in  1 each  control bits.
- mem_valid_o  out  1  register holds a real instruction.
- mem_addr_o  out  DATA_W  registered alu_result.
- mem_wdata_o  out  DATA_W  lane-replicated store data.
- mem_be_o  out  4  byte enables.
- mem_rd_o  out  REG_W  registered rd.
- mem_regwrite_o, mem_memread_o, mem_memwrite_o, mem_memtoreg_o  out  1 each  gated control bits.
- addr_err_o  out  1  misaligned access captured.
- fwd_en_o  out  1  forwarding candidate valid.
- fwd_rd_o  out  REG_W  forwarding destination.
- fwd_data_o  out  DATA_W  forwarding value, equal to mem_addr_o.
- stall_o  out  1  upstream stall request, equal to hold_i (combinational).
- instr_cnt_o  out  CNT_W  count of instructions accepted.

Behaviour:
- Reset: asynchronous, active-high. All outputs and the counter go to 0 immediately; the register holds a bubble.
- Priority at each rising edge: hold_i > flush_i > load.
  - hold_i=1: every register keeps its value. flush_i is ignored; the hazard unit keeps flush asserted until hold drops.
  - hold_i=0, flush_i=1: load a bubble. mem_valid_o=0, all control outputs 0, mem_be_o=0, addr_err_o=0. Data fields load the incoming values, which are don't-care.
  - hold_i=0, flush_i=0: load the inputs.
    - mem_valid_o = ex_valid_i.
    - Control outputs = inputs ANDed with ex_valid_i and with NOT misaligned.
- Latency: one cycle, input to output.
- Byte enables / store data, selected by opcode_i with a = alu_result_i[1:0]:
  - sb (0x28): be = 4'b0001<<a; wdata = store byte replicated ×4.
  - sh (0x29): be = 4'b0011<<(2*a[1]); wdata = halfword ×2.
  - sw (0x2B): be = 4'b1111; wdata = store_data_i.
  - Loads lb/lbu (0x20/0x24), lh/lhu (0x21/0x25), lw (0x23): same be patterns; wdata = store_data_i.
  - Non-memory opcodes: be = 0; wdata = store_data_i.
- Misaligned condition:
  - lh/lhu/sh with a[0]=1, or lw/sw with a!=0.
  - Effect: addr_err_o=1 (only if ex_valid_i); regwrite/memread/memwrite/memtoreg forced 0; be=0; mem_valid_o stays 1.
  - addr_err_o persists for exactly the cycles the instruction occupies the register.
- Forwarding: fwd_en_o = mem_valid_o & mem_regwrite_o & ~mem_memread_o & (mem_rd_o != 0). Loads are never forwarded from this stage.
- Counter: increments by 1 on each load with ex_valid_i=1 and not flushed; wraps from all-ones to 0; frozen during hold.
- Reset mid-hold clears everything; the instruction is lost.

Decomposition:
- Shared package mips_pkg: opcode constants OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW, plus DATA_W and REG_W defaults.
- One combinational sub-module, mem_lane_align: inputs opcode, addr[1:0], store data; outputs be, wdata, misaligned.
- The register and counter stay in the top module.

Test Plan:
- sw, addr 0x100, data 0xDEADBEEF, valid → next cycle be=1111, wdata=0xDEADBEEF, memwrite=1, fwd_en=0.
- sb, addr 0x103, data 0x000000A5 → be=1000, wdata=0xA5A5A5A5; sh, addr 0x102, data 0x1234 → be=1100, wdata=0x12341234.
- lw at addr 0x102 → addr_err=1, memread=0, regwrite=0, be=0, valid=1; next aligned lw at 0x104 → addr_err=0.
- add rd=5, result 7, then hold_i=1 for 3 cycles with new inputs → outputs remain rd=5, data=7, fwd_en=1, counter constant; release → new instruction loads.
- flush_i=1 with valid add → valid=0, regwrite=0, fwd_en=0, counter unchanged; flush+hold together → register holds previous instruction.
- Async reset pulsed mid-cycle with valid content → outputs 0 before the next edge; 2^CNT_W accepts → counter wraps to 0 (bench with CNT_W=4: 16 accepts → 0).

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline.
// Provides memory-opcode constants and default datapath widths used by the
// EX/MEM register and its lane-alignment helper.
package mips_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_W  = 5;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational memory lane aligner.
// Ports:
//   opcode_i     - instruction opcode
//   addr_i       - low two bits of the effective address
//   store_data_i - store operand (post-forwarding B value)
//   be_o         - byte enables for the access (0 for non-memory or misaligned)
//   wdata_o      - store data replicated across the lanes the access may hit
//   misaligned_o - halfword/word access not on its natural boundary
module mem_lane_align
  import mips_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [5:0]        opcode_i,
  input  logic [1:0]        addr_i,
  input  logic [DATA_W-1:0] store_data_i,
  output logic [3:0]        be_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              misaligned_o
);

  logic [3:0] be_raw;

  always_comb begin
    be_raw       = 4'b0000;
    wdata_o      = store_data_i;
    misaligned_o = 1'b0;
    case (opcode_i)
      OP_LB, OP_LBU: be_raw = 4'b0001 << addr_i;
      OP_SB: begin
        be_raw  = 4'b0001 << addr_i;
        // Replicate the byte so the memory sees it on whichever lane is enabled.
        wdata_o = {(DATA_W/8){store_data_i[7:0]}};
      end
      OP_LH, OP_LHU: begin
        be_raw       = 4'b0011 << {addr_i[1], 1'b0};
        misaligned_o = addr_i[0];
      end
      OP_SH: begin
        be_raw       = 4'b0011 << {addr_i[1], 1'b0};
        wdata_o      = {(DATA_W/16){store_data_i[15:0]}};
        misaligned_o = addr_i[0];
      end
      OP_LW, OP_SW: begin
        be_raw       = 4'b1111;
        misaligned_o = |addr_i;
      end
      default: ;
    endcase
    // A misaligned access must never touch memory.
    be_o = misaligned_o ? 4'b0000 : be_raw;
  end

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register.
// Captures the ALU result, lane-aligned store data, byte enables and gated
// control bits; drives the EX-stage forwarding path and counts accepted
// instructions.
// Ports:
//   clock, reset          - rising-edge clock, asynchronous active-high reset
//   hold_i                - memory stage busy: freeze everything
//   flush_i               - replace the incoming instruction with a bubble
//   ex_valid_i ... memtoreg_i - execute-stage instruction fields
//   mem_*_o               - registered memory-stage instruction
//   addr_err_o            - captured instruction is misaligned
//   fwd_en_o/rd_o/data_o  - forwarding candidate for the EX stage
//   stall_o               - upstream stall request (mirrors hold_i)
//   instr_cnt_o           - number of instructions accepted
module ex_mem_reg
  import mips_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W,
  parameter int CNT_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              hold_i,
  input  logic              flush_i,
  input  logic              ex_valid_i,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [DATA_W-1:0] store_data_i,
  input  logic [REG_W-1:0]  rd_i,
  input  logic [5:0]        opcode_i,
  input  logic              regwrite_i,
  input  logic              memread_i,
  input  logic              memwrite_i,
  input  logic              memtoreg_i,
  output logic              mem_valid_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [3:0]        mem_be_o,
  output logic [REG_W-1:0]  mem_rd_o,
  output logic              mem_regwrite_o,
  output logic              mem_memread_o,
  output logic              mem_memwrite_o,
  output logic              mem_memtoreg_o,
  output logic              addr_err_o,
  output logic              fwd_en_o,
  output logic [REG_W-1:0]  fwd_rd_o,
  output logic [DATA_W-1:0] fwd_data_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  instr_cnt_o
);

  logic [3:0]        lane_be;
  logic [DATA_W-1:0] lane_wdata;
  logic              lane_mis;

  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .opcode_i     (opcode_i),
    .addr_i       (alu_result_i[1:0]),
    .store_data_i (store_data_i),
    .be_o         (lane_be),
    .wdata_o      (lane_wdata),
    .misaligned_o (lane_mis)
  );

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [REG_W-1:0]  rd_q, rd_d;
  logic              regwrite_q, regwrite_d;
  logic              memread_q, memread_d;
  logic              memwrite_q, memwrite_d;
  logic              memtoreg_q, memtoreg_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ctrl_ok;

  always_comb begin
    valid_d    = valid_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    rd_d       = rd_q;
    regwrite_d = regwrite_q;
    memread_d  = memread_q;
    memwrite_d = memwrite_q;
    memtoreg_d = memtoreg_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    ctrl_ok    = ex_valid_i & ~lane_mis;
    if (!hold_i) begin
      // Data fields load unconditionally; on a flush they are don't-care.
      addr_d  = alu_result_i;
      wdata_d = lane_wdata;
      rd_d    = rd_i;
      if (flush_i) begin
        valid_d    = 1'b0;
        be_d       = 4'b0000;
        regwrite_d = 1'b0;
        memread_d  = 1'b0;
        memwrite_d = 1'b0;
        memtoreg_d = 1'b0;
        err_d      = 1'b0;
      end else begin
        valid_d    = ex_valid_i;
        be_d       = lane_be;
        regwrite_d = regwrite_i & ctrl_ok;
        memread_d  = memread_i  & ctrl_ok;
        memwrite_d = memwrite_i & ctrl_ok;
        memtoreg_d = memtoreg_i & ctrl_ok;
        err_d      = lane_mis & ex_valid_i;
        if (ex_valid_i) cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= 4'b0000;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      rd_q       <= rd_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      memtoreg_q <= memtoreg_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign mem_valid_o    = valid_q;
  assign mem_addr_o     = addr_q;
  assign mem_wdata_o    = wdata_q;
  assign mem_be_o       = be_q;
  assign mem_rd_o       = rd_q;
  assign mem_regwrite_o = regwrite_q;
  assign mem_memread_o  = memread_q;
  assign mem_memwrite_o = memwrite_q;
  assign mem_memtoreg_o = memtoreg_q;
  assign addr_err_o     = err_q;
  assign instr_cnt_o    = cnt_q;
  assign stall_o        = hold_i;

  // Load data is not available until MEM completes, so loads never forward here.
  assign fwd_en_o   = valid_q & regwrite_q & ~memread_q & (rd_q != '0);
  assign fwd_rd_o   = rd_q;
  assign fwd_data_o = addr_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
module tb_ex_mem_reg;
  localparam int CNT_W = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        hold_i = 1'b0, flush_i = 1'b0, ex_valid_i = 1'b0;
  logic [31:0] alu_result_i = '0, store_data_i = '0;
  logic [4:0]  rd_i = '0;
  logic [5:0]  opcode_i = '0;
  logic        regwrite_i = 1'b0, memread_i = 1'b0, memwrite_i = 1'b0, memtoreg_i = 1'b0;
  logic        mem_valid_o, mem_regwrite_o, mem_memread_o, mem_memwrite_o, mem_memtoreg_o;
  logic [31:0] mem_addr_o, mem_wdata_o, fwd_data_o;
  logic [3:0]  mem_be_o;
  logic [4:0]  mem_rd_o, fwd_rd_o;
  logic        addr_err_o, fwd_en_o, stall_o;
  logic [CNT_W-1:0] instr_cnt_o;

  ex_mem_reg #(.DATA_W(32), .REG_W(5), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .hold_i(hold_i), .flush_i(flush_i),
    .ex_valid_i(ex_valid_i), .alu_result_i(alu_result_i), .store_data_i(store_data_i),
    .rd_i(rd_i), .opcode_i(opcode_i), .regwrite_i(regwrite_i), .memread_i(memread_i),
    .memwrite_i(memwrite_i), .memtoreg_i(memtoreg_i), .mem_valid_o(mem_valid_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_rd_o(mem_rd_o), .mem_regwrite_o(mem_regwrite_o), .mem_memread_o(mem_memread_o),
    .mem_memwrite_o(mem_memwrite_o), .mem_memtoreg_o(mem_memtoreg_o),
    .addr_err_o(addr_err_o), .fwd_en_o(fwd_en_o), .fwd_rd_o(fwd_rd_o),
    .fwd_data_o(fwd_data_o), .stall_o(stall_o), .instr_cnt_o(instr_cnt_o)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  // ctrl / e_ctrl are {regwrite, memread, memwrite, memtoreg}
  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        v;
    logic        fl;
    logic [3:0]  ctrl;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic        e_v;
    logic [3:0]  e_ctrl;
    logic        e_err;
    logic        e_fwd;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] sd,
                       input logic [4:0] rd, input logic v, input logic [3:0] ctrl);
    opcode_i = op; alu_result_i = addr; store_data_i = sd; rd_i = rd; ex_valid_i = v;
    {regwrite_i, memread_i, memwrite_i, memtoreg_i} = ctrl;
  endtask

  function automatic logic [3:0] ctrl_out();
    return {mem_regwrite_o, mem_memread_o, mem_memwrite_o, mem_memtoreg_o};
  endfunction

  initial begin
    vecs[0]  = '{6'h2B, 32'h100, 32'hDEADBEEF, 5'd0, 1, 0, 4'b0010, 4'hF, 32'hDEADBEEF, 1, 4'b0010, 0, 0};
    vecs[1]  = '{6'h28, 32'h103, 32'h000000A5, 5'd0, 1, 0, 4'b0010, 4'h8, 32'hA5A5A5A5, 1, 4'b0010, 0, 0};
    vecs[2]  = '{6'h29, 32'h102, 32'h00001234, 5'd0, 1, 0, 4'b0010, 4'hC, 32'h12341234, 1, 4'b0010, 0, 0};
    vecs[3]  = '{6'h23, 32'h102, 32'h0,        5'd8, 1, 0, 4'b1101, 4'h0, 32'h0,        1, 4'b0000, 1, 0};
    vecs[4]  = '{6'h23, 32'h104, 32'h0,        5'd8, 1, 0, 4'b1101, 4'hF, 32'h0,        1, 4'b1101, 0, 0};
    vecs[5]  = '{6'h00, 32'h7,   32'h55,       5'd5, 1, 0, 4'b1000, 4'h0, 32'h55,       1, 4'b1000, 0, 1};
    vecs[6]  = '{6'h21, 32'h101, 32'h0,        5'd9, 1, 0, 4'b1101, 4'h0, 32'h0,        1, 4'b0000, 1, 0};
    vecs[7]  = '{6'h25, 32'h106, 32'h0,        5'd9, 1, 0, 4'b1101, 4'hC, 32'h0,        1, 4'b1101, 0, 0};
    vecs[8]  = '{6'h20, 32'h102, 32'h0,        5'd3, 1, 0, 4'b1101, 4'h4, 32'h0,        1, 4'b1101, 0, 0};
    vecs[9]  = '{6'h29, 32'h101, 32'h0000BEEF, 5'd0, 1, 0, 4'b0010, 4'h0, 32'hBEEFBEEF, 1, 4'b0000, 1, 0};
    vecs[10] = '{6'h00, 32'h9,   32'h0,        5'd0, 1, 0, 4'b1000, 4'h0, 32'h0,        1, 4'b1000, 0, 0};
    vecs[11] = '{6'h23, 32'h102, 32'h0,        5'd4, 0, 0, 4'b1101, 4'h0, 32'h0,        0, 4'b0000, 0, 0};
    vecs[12] = '{6'h00, 32'h3,   32'h0,        5'd6, 1, 1, 4'b1000, 4'h0, 32'h0,        0, 4'b0000, 0, 0};
    vecs[13] = '{6'h2B, 32'h10F, 32'h12345678, 5'd0, 1, 0, 4'b0010, 4'h0, 32'h12345678, 1, 4'b0000, 1, 0};
    vecs[14] = '{6'h24, 32'h10F, 32'h0,        5'd2, 1, 0, 4'b1101, 4'h8, 32'h0,        1, 4'b1101, 0, 0};
    vecs[15] = '{6'h00, 32'hAB,  32'h0,        5'd7, 0, 0, 4'b1000, 4'h0, 32'h0,        0, 4'b0000, 0, 0};

    // Reset state while reset is asserted.
    #12;
    chk("rst_valid", 32'(mem_valid_o), 32'h0);
    chk("rst_addr", mem_addr_o, 32'h0);
    chk("rst_be", 32'(mem_be_o), 32'h0);
    chk("rst_cnt", 32'(instr_cnt_o), 32'h0);
    chk("rst_fwd", 32'(fwd_en_o), 32'h0);
    reset = 1'b0;

    // Table-driven single-cycle loads.
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].op, vecs[i].addr, vecs[i].sd, vecs[i].rd, vecs[i].v, vecs[i].ctrl);
      flush_i = vecs[i].fl;
      step();
      if (!vecs[i].fl && vecs[i].v) exp_cnt = exp_cnt + 1'b1;
      $display("[TB] vec %0d op=%h addr=%h v=%0d flush=%0d be=%h err=%0d", i, vecs[i].op,
               vecs[i].addr, vecs[i].v, vecs[i].fl, mem_be_o, addr_err_o);
      chk($sformatf("v%0d_be", i), 32'(mem_be_o), 32'(vecs[i].e_be));
      chk($sformatf("v%0d_valid", i), 32'(mem_valid_o), 32'(vecs[i].e_v));
      chk($sformatf("v%0d_ctrl", i), 32'(ctrl_out()), 32'(vecs[i].e_ctrl));
      chk($sformatf("v%0d_err", i), 32'(addr_err_o), 32'(vecs[i].e_err));
      chk($sformatf("v%0d_fwd", i), 32'(fwd_en_o), 32'(vecs[i].e_fwd));
      chk($sformatf("v%0d_cnt", i), 32'(instr_cnt_o), 32'(exp_cnt));
      chk($sformatf("v%0d_stall", i), 32'(stall_o), 32'h0);
      if (!vecs[i].fl) begin
        chk($sformatf("v%0d_wdata", i), mem_wdata_o, vecs[i].e_wd);
        chk($sformatf("v%0d_addr", i), mem_addr_o, vecs[i].addr);
        chk($sformatf("v%0d_fwd_data", i), fwd_data_o, vecs[i].addr);
        chk($sformatf("v%0d_rd", i), 32'(mem_rd_o), 32'(vecs[i].rd));
        chk($sformatf("v%0d_fwd_rd", i), 32'(fwd_rd_o), 32'(vecs[i].rd));
      end
    end
    flush_i = 1'b0;

    // Hold: add rd=5 result 7, then 3 held cycles with different inputs.
    drive(6'h00, 32'h7, 32'h0, 5'd5, 1'b1, 4'b1000);
    step();
    exp_cnt = exp_cnt + 1'b1;
    $display("[TB] hold setup: add rd=5 data=7");
    drive(6'h2B, 32'h200, 32'hCAFEF00D, 5'd12, 1'b1, 4'b0010);
    hold_i = 1'b1;
    #1;
    chk("hold_stall_comb", 32'(stall_o), 32'h1);
    for (int c = 0; c < 3; c++) begin
      step();
      $display("[TB] hold cycle %0d rd=%0d data=%h", c, mem_rd_o, fwd_data_o);
      chk("hold_rd", 32'(mem_rd_o), 32'd5);
      chk("hold_data", fwd_data_o, 32'h7);
      chk("hold_fwd", 32'(fwd_en_o), 32'h1);
      chk("hold_cnt", 32'(instr_cnt_o), 32'(exp_cnt));
    end
    // Flush together with hold: hold wins.
    flush_i = 1'b1;
    step();
    $display("[TB] hold+flush valid=%0d rd=%0d", mem_valid_o, mem_rd_o);
    chk("holdflush_valid", 32'(mem_valid_o), 32'h1);
    chk("holdflush_rd", 32'(mem_rd_o), 32'd5);
    chk("holdflush_rw", 32'(mem_regwrite_o), 32'h1);
    // Release: held-back store loads.
    hold_i = 1'b0; flush_i = 1'b0;
    #1;
    chk("release_stall", 32'(stall_o), 32'h0);
    step();
    exp_cnt = exp_cnt + 1'b1;
    $display("[TB] release sw addr=%h", mem_addr_o);
    chk("release_addr", mem_addr_o, 32'h200);
    chk("release_mw", 32'(mem_memwrite_o), 32'h1);
    chk("release_cnt", 32'(instr_cnt_o), 32'(exp_cnt));

    // Flush alone on a valid add.
    drive(6'h00, 32'h11, 32'h0, 5'd6, 1'b1, 4'b1000);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    $display("[TB] flush add valid=%0d", mem_valid_o);
    chk("flush_valid", 32'(mem_valid_o), 32'h0);
    chk("flush_rw", 32'(mem_regwrite_o), 32'h0);
    chk("flush_fwd", 32'(fwd_en_o), 32'h0);
    chk("flush_cnt", 32'(instr_cnt_o), 32'(exp_cnt));

    // Asynchronous reset mid-cycle with valid content.
    drive(6'h00, 32'h33, 32'h0, 5'd5, 1'b1, 4'b1000);
    step();
    chk("prereset_fwd", 32'(fwd_en_o), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    $display("[TB] async reset valid=%0d cnt=%0d", mem_valid_o, instr_cnt_o);
    chk("areset_valid", 32'(mem_valid_o), 32'h0);
    chk("areset_addr", mem_addr_o, 32'h0);
    chk("areset_rd", 32'(mem_rd_o), 32'h0);
    chk("areset_fwd", 32'(fwd_en_o), 32'h0);
    chk("areset_cnt", 32'(instr_cnt_o), 32'h0);
    #1;
    reset = 1'b0;
    exp_cnt = '0;

    // Counter wrap: 15 accepts -> 15, 16th -> 0.
    drive(6'h00, 32'h1, 32'h0, 5'd1, 1'b1, 4'b1000);
    for (int k = 1; k <= 16; k++) begin
      step();
      exp_cnt = exp_cnt + 1'b1;
      $display("[TB] wrap accept %0d cnt=%0d", k, instr_cnt_o);
      if (k == 15) chk("wrap_15", 32'(instr_cnt_o), 32'd15);
      if (k == 16) chk("wrap_0", 32'(instr_cnt_o), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
